seg_display: RTL and testbench

- Parametrised N-digit 7-segment display controller; successor to the fixed 8-digit decimal segment driver.
- Latches a packed hex word on a load strobe and decodes it to full hex glyphs (0-F), with per-digit decimal point and blanking.
- A prescaler drives static, scroll-left and blink display modes.
- Sits between the core's debug/status registers and the board seven-segment pins.

---
 rtl/seg_display_if.sv | 23 ++
 rtl/seg_display.sv | 113 +++++++++++
 tb/tb_seg_display.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_if.sv
// Bundles the load/data inputs and the segment/tick outputs of seg_display.
// The bus master drives the hex word and strobes; the slave returns the segment pins.
interface seg_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] i_data;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [NUM_DIGITS-1:0]   i_blank;
  logic                    i_load;
  logic [1:0]              i_mode;
  logic [8*NUM_DIGITS-1:0] o_seg;
  logic                    o_tick;

  modport master (
    output i_data, i_dp, i_blank, i_load, i_mode,
    input  o_seg, o_tick
  );

  modport slave (
    input  i_data, i_dp, i_blank, i_load, i_mode,
    output o_seg, o_tick
  );
endinterface

// File: rtl/seg_display.sv
// N-digit hex 7-segment controller with static, scroll-left and blink modes.
// Shadow registers hold the loaded word; a free-running prescaler paces scroll and blink.
module seg_display #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 5000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          rst,
  seg_display_if.slave  bus
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int OFF_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_SCROLL = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  function automatic logic [7:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return 8'hFC;  4'h1: return 8'h60;  4'h2: return 8'hDA;  4'h3: return 8'hF2;
      4'h4: return 8'h66;  4'h5: return 8'hB6;  4'h6: return 8'hBE;  4'h7: return 8'hE0;
      4'h8: return 8'hFE;  4'h9: return 8'hF6;  4'hA: return 8'hEE;  4'hB: return 8'h3E;
      4'hC: return 8'h9C;  4'hD: return 8'h7A;  4'hE: return 8'h9E;  default: return 8'h8E;
    endcase
  endfunction

  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OFF_W-1:0]        off_q, off_d;
  logic                    blink_q, blink_d;
  mode_e                   mode_q, mode_d;
  logic                    tick_q, tick_d;
  logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    wrap, mode_chg;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_d   = data_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    mode_d   = mode_e'(bus.i_mode);
    mode_chg = (mode_e'(bus.i_mode) != mode_q);
    wrap     = (cnt_q == CNT_W'(CLK_DIV - 1));
    tick_d   = wrap;
    cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
    off_d    = '0;
    blink_d  = 1'b1;

    if (bus.i_load) begin
      data_d  = bus.i_data;
      dp_d    = bus.i_dp;
      blank_d = bus.i_blank;
    end

    // A mode change restarts the display timebase so the new mode begins from a clean phase.
    if (mode_chg) begin
      cnt_d = '0;
    end else if (mode_q == MODE_SCROLL) begin
      off_d = off_q;
      if (wrap) off_d = (off_q == OFF_W'(NUM_DIGITS - 1)) ? '0 : off_q + OFF_W'(1);
    end else if (mode_q == MODE_BLINK) begin
      blink_d = wrap ? ~blink_q : blink_q;
    end
  end

  always_comb begin : render
    int         src;
    logic [7:0] glyph_v;
    seg_d = '0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      // Sum is below 2*NUM_DIGITS, so one conditional subtract is an exact modulo.
      src = j + int'(off_q);
      if (src >= NUM_DIGITS) src = src - NUM_DIGITS;
      glyph_v = glyph(data_q[4*src +: 4]) | {7'b0, dp_q[src]};
      if (blank_q[src] || !blink_q) glyph_v = 8'h00;
      seg_d[8*j +: 8] = (ACTIVE_LOW != 0) ? ~glyph_v : glyph_v;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      blink_q <= 1'b1;
      mode_q  <= MODE_STATIC;
      tick_q  <= 1'b0;
      seg_q   <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      data_q  <= data_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      blink_q <= blink_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.o_seg  = seg_q;
  assign bus.o_tick = tick_q;
endmodule

// File: tb/tb_seg_display.sv
// Bench for seg_display: an 8-digit active-low and a 6-digit active-high instance share stimulus
// and are compared every cycle against an arithmetic model, plus hand-computed glyph expectations.
module tb_seg_display;
  localparam int DIV = 4;
  localparam logic [63:0] ALL_FF = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] t_data;
  logic [7:0]  t_dp, t_blank;
  logic        t_load;
  logic [1:0]  t_mode;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  seg_display_if #(.NUM_DIGITS(8)) bus8();
  seg_display_if #(.NUM_DIGITS(6)) bus6();

  assign bus8.i_data  = t_data;
  assign bus8.i_dp    = t_dp;
  assign bus8.i_blank = t_blank;
  assign bus8.i_load  = t_load;
  assign bus8.i_mode  = t_mode;
  assign bus6.i_data  = t_data[23:0];
  assign bus6.i_dp    = t_dp[5:0];
  assign bus6.i_blank = t_blank[5:0];
  assign bus6.i_load  = t_load;
  assign bus6.i_mode  = t_mode;

  seg_display #(.NUM_DIGITS(8), .CLK_DIV(DIV), .ACTIVE_LOW(1)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  seg_display #(.NUM_DIGITS(6), .CLK_DIV(DIV), .ACTIVE_LOW(0)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
  logic [31:0] m_data  [2];
  logic [7:0]  m_dp    [2];
  logic [7:0]  m_blank [2];
  int          m_cnt   [2];
  int          m_off   [2];
  bit          m_blink [2];
  logic [1:0]  m_mode  [2];
  bit          m_tick  [2];
  logic [63:0] m_seg   [2];

  function automatic int ndig(input int id);
    return (id == 0) ? 8 : 6;
  endfunction

  function automatic logic [63:0] render(input int id);
    logic [63:0] w;
    logic [7:0]  b;
    int          s;
    w = '0;
    for (int j = 0; j < ndig(id); j++) begin
      s = (j + m_off[id]) % ndig(id);
      b = glyph_tab[m_data[id][4*s +: 4]] | {7'b0, m_dp[id][s]};
      if (m_blank[id][s] || !m_blink[id]) b = 8'h00;
      if (id == 0) b = ~b;
      w[8*j +: 8] = b;
    end
    return w;
  endfunction

  task automatic model_step(input int id);
    bit wrap;
    if (rst) begin
      m_data[id] = '0; m_dp[id] = '0; m_blank[id] = '0;
      m_cnt[id] = 0; m_off[id] = 0; m_blink[id] = 1'b1; m_mode[id] = 2'b00;
      m_tick[id] = 1'b0;
      m_seg[id] = (id == 0) ? ALL_FF : 64'h0;
    end else begin
      m_seg[id]  = render(id);
      wrap       = (m_cnt[id] == DIV - 1);
      m_tick[id] = wrap;
      if (t_load) begin
        m_data[id] = t_data; m_dp[id] = t_dp; m_blank[id] = t_blank;
      end
      if (t_mode != m_mode[id]) begin
        m_cnt[id] = 0; m_off[id] = 0; m_blink[id] = 1'b1;
      end else begin
        m_cnt[id] = (m_cnt[id] + 1) % DIV;
        if (t_mode == 2'b01 && wrap) m_off[id] = (m_off[id] + 1) % ndig(id);
        if (t_mode == 2'b10 && wrap) m_blink[id] = !m_blink[id];
      end
      m_mode[id] = t_mode;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("seg8",  bus8.o_seg, m_seg[0]);
      check("tick8", 64'(bus8.o_tick), 64'(m_tick[0]));
      check("seg6",  64'(bus6.o_seg), m_seg[1]);
      check("tick6", 64'(bus6.o_tick), 64'(m_tick[1]));
    end
  end

  function automatic logic [7:0] b8(input int j);
    return bus8.o_seg[8*j +: 8];
  endfunction

  function automatic logic [7:0] b6(input int j);
    return bus6.o_seg[8*j +: 8];
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    t_data = d; t_dp = dp; t_blank = bl; t_load = 1'b1;
    step();
    t_load = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus8.o_tick !== 1'b1 && n < 20);
    if (bus8.o_tick !== 1'b1) check("tick_timeout", 64'(bus8.o_tick), 64'd1);
  endtask

  initial begin
    int n;
    int budget;
    rst = 1'b1; t_data = '0; t_dp = '0; t_blank = '0; t_load = 1'b0; t_mode = 2'b00;
    step(2);
    cmp_en = 1'b1;
    check("reset_seg8", bus8.o_seg, ALL_FF);
    check("reset_seg6", 64'(bus6.o_seg), 64'h0);
    check("reset_tick", 64'(bus8.o_tick), 64'd0);
    rst = 1'b0;

    // Hex decode, two edges after the load strobe.
    load(32'hFEDC_BA98, 8'h00, 8'h00);
    step();
    check("decode_byte0", 64'(b8(0)), 64'h01);
    check("decode_byte7", 64'(b8(7)), 64'h71);

    // Decimal point and blanking.
    load(32'h0000_0012, 8'h01, 8'hFC);
    step();
    check("dp_blank8", bus8.o_seg, 64'hFFFF_FFFF_FFFF_9F24);
    check("dp_blank6", 64'(bus6.o_seg), 64'h0000_0000_60DB);

    // Scroll-left; the mode change on the load edge restarts the prescaler.
    t_mode = 2'b01;
    load(32'h7654_3210, 8'h00, 8'h00);
    wait_tick(n);
    check("first_tick_gap", 64'(n), 64'd4);
    step();
    check("scroll1_byte0", 64'(b8(0)), 64'h9F);
    check("scroll1_n6_byte5", 64'(b6(5)), 64'hFC);
    wait_tick(n);
    check("tick_period", 64'(n + 1), 64'd4);
    repeat (6) wait_tick(n);
    step();
    check("scroll8_byte0", 64'(b8(0)), 64'h03);
    check("scroll8_n6_byte0", 64'(b6(0)), 64'hDA);

    // Load on the same edge as a scroll tick.
    budget = 0;
    while (m_cnt[0] != DIV - 1 && budget < 10) begin
      step();
      budget++;
    end
    load(32'hFEDC_BA98, 8'h00, 8'h00);
    step();
    check("load_tick_byte0", 64'(b8(0)), 64'h09);
    check("load_tick_n6_byte0", 64'(b6(0)), 64'h3E);

    // Reset in the middle of scrolling.
    step(2);
    rst = 1'b1;
    step();
    check("midrst_seg", bus8.o_seg, ALL_FF);
    check("midrst_tick", 64'(bus8.o_tick), 64'd0);
    rst = 1'b0;

    // Blink, then leave blink during the off phase.
    t_mode = 2'b10;
    load(32'h7654_3210, 8'h00, 8'h00);
    wait_tick(n);
    step();
    check("blink_off", bus8.o_seg, ALL_FF);
    t_mode = 2'b00;
    step(2);
    check("blink_exit_byte0", 64'(b8(0)), 64'h03);
    wait_tick(n);
    check("blink_exit_restart", 64'(n + 2), 64'd5);

    // Randomised traffic, including reserved mode and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      t_load  = ($urandom_range(0, 5) == 0);
      t_data  = $urandom();
      t_dp    = 8'($urandom());
      t_blank = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
      if ($urandom_range(0, 39) == 0) t_mode = 2'($urandom());
      step();
    end
    rst = 1'b0; t_load = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
